// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: state encoding,
// MIPS-subset opcodes and the datapath mux / ALU control encodings.
package mc_ctrl_pkg;

    // Sequencer states. RESET must stay at 0 so a cleared register is idle.
    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_ALUWB   = 4'd8,
        S_ADDI_EX = 4'd9,
        S_ADDIWB  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    // Supported opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // ALU operation select.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select.
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for every opcode the sequencer knows how to execute.
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational control-strobe decode for the multi-cycle sequencer.
// Every strobe is a Moore function of the state, except IRWrite and PCWrite
// in FETCH, which only fire in the cycle memory delivers the instruction.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source
);

    // Per-state strobe table; anything not listed for a state stays 0.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMMSH2;
            end
            S_MEMADR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS-subset control sequencer.
// Optional build macro: PERF_COUNT_EN adds RetiredCount / StallCount.
//
// Memory handshake: an access in FETCH, MEMRD or MEMWR keeps its request
// strobe asserted and the state held until MemReady is sampled high at a
// rising edge; that edge completes the access and advances the state.
module multicycle_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  Opcode,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSource,
    output logic [3:0]  State,
`ifdef PERF_COUNT_EN
    output logic [31:0] RetiredCount,
    output logic [31:0] StallCount,
`endif
    output logic        IllegalOp
);

    state_t state;
    // Remembers in DECODE whether a memory instruction is a store, so
    // MEMADR does not depend on the opcode staying valid afterwards.
    logic   is_store;

    // State register and next-state sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RESET;
            is_store <= 1'b0;
        end else begin
            case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (MemReady) state <= S_DECODE;
                S_DECODE: begin
                    is_store <= (Opcode == OP_SW);
                    case (Opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXEC;
                        OP_ADDI:      state <= S_ADDI_EX;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (MemReady) state <= S_MEMWB;
                S_MEMWR:   if (MemReady) state <= S_FETCH;
                S_EXEC:    state <= S_ALUWB;
                S_ADDI_EX: state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state <= S_FETCH;
                default:   state <= S_RESET;
            endcase
        end
    end

    assign State     = state;
    // Unknown opcodes are flagged for their DECODE cycle only, then dropped.
    assign IllegalOp = (state == S_DECODE) && !is_known_op(Opcode);

    mc_ctrl_outdec u_outdec (
        .state         (state),
        .mem_ready     (MemReady),
        .pc_write      (PCWrite),
        .pc_write_cond (PCWriteCond),
        .iord          (IorD),
        .mem_read      (MemRead),
        .mem_write     (MemWrite),
        .ir_write      (IRWrite),
        .mem_to_reg    (MemToReg),
        .reg_write     (RegWrite),
        .reg_dst       (RegDst),
        .alu_src_a     (ALUSrcA),
        .alu_src_b     (ALUSrcB),
        .alu_op        (ALUOp),
        .pc_source     (PCSource)
    );

`ifdef PERF_COUNT_EN
    logic retire;
    logic stall;

    // An instruction retires on the edge that returns from its final state
    // to FETCH; a stall is any cycle an access waits on memory.
    always_comb begin
        retire = 1'b0;
        stall  = 1'b0;
        case (state)
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR: begin
                retire = MemReady;
                stall  = !MemReady;
            end
            S_FETCH, S_MEMRD: stall = !MemReady;
            default: ;
        endcase
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RetiredCount <= 32'd0;
            StallCount   <= 32'd0;
        end else begin
            if (retire) RetiredCount <= RetiredCount + 32'd1;
            if (stall)  StallCount   <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-level reference model feeding
// an expected-vector queue, checked each cycle by an independent monitor.
module tb_multicycle_control_fsm;
    import mc_ctrl_pkg::*;

    localparam int W = 21;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_write, reg_dst, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state_dbg;
`ifdef PERF_COUNT_EN
    logic [31:0] retired_count, stall_count;
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Opcode       (opcode),
        .MemReady     (mem_ready),
        .PCWrite      (pc_write),
        .PCWriteCond  (pc_write_cond),
        .IorD         (iord),
        .MemRead      (mem_read),
        .MemWrite     (mem_write),
        .IRWrite      (ir_write),
        .MemToReg     (mem_to_reg),
        .RegWrite     (reg_write),
        .RegDst       (reg_dst),
        .ALUSrcA      (alu_src_a),
        .ALUSrcB      (alu_src_b),
        .ALUOp        (alu_op),
        .PCSource     (pc_source),
        .State        (state_dbg),
`ifdef PERF_COUNT_EN
        .RetiredCount (retired_count),
        .StallCount   (stall_count),
`endif
        .IllegalOp    (illegal_op)
    );

    wire [W-1:0] act = {pc_write, pc_write_cond, iord, mem_read, mem_write,
                        ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a,
                        alu_src_b, alu_op, pc_source, state_dbg, illegal_op};

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int  tests = 0;
    int  fails = 0;
    bit  mon_en = 1'b0;
    int  model_retired = 0;
    int  model_stalls = 0;

    // Expected control vector for a cycle spent in state s, straight from the
    // per-state strobe list (unlisted strobes are 0).
    function automatic logic [W-1:0] exp_vec(state_t s, logic mr, logic ill);
        logic pcw, pcwc, io, mrd, mwr, irw, m2r, rw, rd, sa, illo;
        logic [1:0] sb, ao, ps;
        pcw = 0; pcwc = 0; io = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
        rw = 0; rd = 0; sa = 0; illo = 0; sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (s)
            S_FETCH:   begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            S_DECODE:  begin sb = 2'b11; illo = ill; end
            S_MEMADR:  begin sa = 1; sb = 2'b10; end
            S_MEMRD:   begin mrd = 1; io = 1; end
            S_MEMWB:   begin rw = 1; m2r = 1; end
            S_MEMWR:   begin mwr = 1; io = 1; end
            S_EXEC:    begin sa = 1; ao = 2'b10; end
            S_ALUWB:   begin rw = 1; rd = 1; end
            S_ADDI_EX: begin sa = 1; sb = 2'b10; end
            S_ADDIWB:  begin rw = 1; end
            S_BRANCH:  begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
            S_JUMP:    begin pcw = 1; ps = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, io, mrd, mwr, irw, m2r, rw, rd, sa, sb, ao, ps,
                4'(s), illo};
    endfunction

    function automatic logic legal_op(logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL ctrl_underflow: got %0h expected none at %0t", act, $time);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (act !== e) begin
                    fails++;
                    $display("FAIL ctrl: got %06h expected %06h state %0d at %0t",
                             act, e, state_dbg, $time);
                end
            end
            tests++;
            if ((mem_read && mem_write) || (reg_write && mem_read)) begin
                fails++;
                $display("FAIL invariant: got rd=%0b wr=%0b rw=%0b expected exclusive at %0t",
                         mem_read, mem_write, reg_write, $time);
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1: drive MemReady, record expectation, finish the cycle.
    task automatic step(state_t s, logic mr, logic ill);
        mem_ready = mr;
        exp_q.push_back(exp_vec(s, mr, ill));
        @(posedge clk);
        #1;
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic mem_wait(state_t s, int stalls);
        for (int i = 0; i < stalls; i++) step(s, 1'b0, 1'b0);
        step(s, 1'b1, 1'b0);
    endtask

    // One whole instruction: FETCH with fs wait cycles, memory phase with ms.
    task automatic run_instr(logic [5:0] op, int fs, int ms);
        logic ok;
        ok = legal_op(op);
        opcode = op;
        mem_wait(S_FETCH, fs);
        step(S_DECODE, rnd_bit(), !ok);
        model_stalls += fs;
        case (op)
            6'h23: begin
                step(S_MEMADR, rnd_bit(), 1'b0);
                mem_wait(S_MEMRD, ms);
                step(S_MEMWB, rnd_bit(), 1'b0);
                model_stalls += ms;
            end
            6'h2B: begin
                step(S_MEMADR, rnd_bit(), 1'b0);
                mem_wait(S_MEMWR, ms);
                model_stalls += ms;
            end
            6'h00: begin
                step(S_EXEC, rnd_bit(), 1'b0);
                step(S_ALUWB, rnd_bit(), 1'b0);
            end
            6'h08: begin
                step(S_ADDI_EX, rnd_bit(), 1'b0);
                step(S_ADDIWB, rnd_bit(), 1'b0);
            end
            6'h04: step(S_BRANCH, rnd_bit(), 1'b0);
            6'h02: step(S_JUMP, rnd_bit(), 1'b0);
            default: ;
        endcase
        if (ok) model_retired++;
    endtask

    task automatic check_counters(string tag);
`ifdef PERF_COUNT_EN
        check({tag, "_retired"}, 64'(retired_count), 64'(model_retired));
        check({tag, "_stalls"}, 64'(stall_count), 64'(model_stalls));
`else
        check({tag, "_queue_idle"}, 64'(exp_q.size()), 64'd0);
`endif
    endtask

    // Assert reset (outputs must clear at once), hold, release, expect RESET.
    task automatic do_reset();
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'(act), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_outputs", 64'(act), 64'd0);
        model_retired = 0;
        model_stalls = 0;
        check_counters("reset");
        rst_n = 1'b1;
        mon_en = 1'b1;
        step(S_RESET, rnd_bit(), 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        ops[4] = 6'h02; ops[5] = 6'h08; ops[6] = 6'h3F; ops[7] = 6'h01;

        #2;
        do_reset();

        run_instr(6'h23, 0, 0);     // lw, no waits
        run_instr(6'h2B, 0, 3);     // sw, three MEMWR waits
        check_counters("after_sw");
        run_instr(6'h00, 0, 0);     // R-type
        run_instr(6'h04, 0, 0);     // beq
        run_instr(6'h3F, 0, 0);     // illegal
        check_counters("after_illegal");
        run_instr(6'h08, 2, 0);     // addi with two FETCH waits
        run_instr(6'h02, 0, 0);     // j
        check_counters("directed");

        // Reset while lw is waiting in MEMRD.
        opcode = 6'h23;
        step(S_FETCH, 1'b1, 1'b0);
        step(S_DECODE, 1'b1, 1'b0);
        step(S_MEMADR, 1'b1, 1'b0);
        mem_ready = 1'b0;
        exp_q.push_back(exp_vec(S_MEMRD, 1'b0, 1'b0));
        @(negedge clk);
        #1;
        do_reset();

        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'h01) begin
                op = 6'($urandom_range(0, 63));
                while (legal_op(op)) op = 6'($urandom_range(0, 63));
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        check_counters("random");

        mon_en = 1'b0;
        check("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        fails++;
        $display("FAIL timeout: got no completion expected finish by %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
